// File: rtl/z86_io_sim.sv
// z86 I/O-space responder: byte-addressed register window with programmable latency and access counters.
// Optional macro IO_TRACE_EN prints one line per completed access (plus a warning for unmapped bytes).
module z86_io_sim #(
  parameter int          NPORTS       = 8,
  parameter logic [15:0] BASE_ADDR    = 16'h0300,
  parameter int          LATENCY      = 1,
  parameter logic [15:0] DEFAULT_DATA = 16'hFFFF
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        io_read_do,
  input  logic [15:0] io_read_address,
  input  logic        io_read_word,
  output logic [15:0] io_read_data,
  output logic        io_read_done,
  input  logic        io_write_do,
  input  logic [15:0] io_write_address,
  input  logic        io_write_word,
  input  logic [15:0] io_write_data,
  output logic        io_write_done,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam int          NBYTES   = 2 * NPORTS;
  localparam int          IDX_W    = (NBYTES > 2) ? $clog2(NBYTES) : 1;
  localparam logic [16:0] WIN      = 17'(NBYTES);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        op_wr_q, op_wr_d;
  logic [15:0] addr_q, addr_d;
  logic        word_q, word_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] rd_count_q, rd_count_d;
  logic [15:0] wr_count_q, wr_count_d;
  logic [7:0]  mem_q [NBYTES];
  logic [7:0]  mem_d [NBYTES];

  logic        fire;
  logic [15:0] addr_hi;
  logic        lo_map, hi_map;
  logic [7:0]  lo_byte, hi_byte;
  logic [15:0] rd_val;

  // The 16-bit subtraction wraps, so addresses below BASE_ADDR decode as large offsets.
  function automatic logic is_mapped(input logic [15:0] a);
    logic [15:0] off;
    off = a - BASE_ADDR;
    return ({1'b0, off} < WIN);
  endfunction

  function automatic logic [IDX_W-1:0] byte_idx(input logic [15:0] a);
    logic [15:0] off;
    off = a - BASE_ADDR;
    return off[IDX_W-1:0];
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign addr_hi = addr_q + 16'd1;
  assign lo_map  = is_mapped(addr_q);
  assign hi_map  = is_mapped(addr_hi);
  assign lo_byte = lo_map ? mem_q[byte_idx(addr_q)] : DEFAULT_DATA[7:0];
  assign hi_byte = (word_q && hi_map) ? mem_q[byte_idx(addr_hi)] : DEFAULT_DATA[15:8];
  assign rd_val  = {hi_byte, lo_byte};
  assign fire    = (state_q == S_BUSY) && (cnt_q == 4'd0);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Write wins over a simultaneous read; the read stays pending until IDLE returns.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (io_write_do) begin
          op_wr_d = 1'b1;
          addr_d  = io_write_address;
          word_d  = io_write_word;
          wdata_d = io_write_data;
          cnt_d   = CNT_INIT;
          state_d = S_BUSY;
        end else if (io_read_do) begin
          op_wr_d = 1'b0;
          addr_d  = io_read_address;
          word_d  = io_read_word;
          cnt_d   = CNT_INIT;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_HOLD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    io_read_done  = fire && !op_wr_q;
    io_write_done = fire && op_wr_q;
    io_read_data  = io_read_done ? rd_val : rdata_q;
  end

  always_comb begin
    mem_d      = mem_q;
    rdata_d    = rdata_q;
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if (fire) begin
      if (op_wr_q) begin
        if (lo_map) mem_d[byte_idx(addr_q)] = wdata_q[7:0];
        if (word_q && hi_map) mem_d[byte_idx(addr_hi)] = wdata_q[15:8];
        wr_count_d = sat_inc(wr_count_q);
      end else begin
        rdata_d    = rd_val;
        rd_count_d = sat_inc(rd_count_q);
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= 4'd0;
      op_wr_q    <= 1'b0;
      addr_q     <= 16'd0;
      word_q     <= 1'b0;
      wdata_q    <= 16'd0;
      rdata_q    <= DEFAULT_DATA;
      rd_count_q <= 16'd0;
      wr_count_q <= 16'd0;
      mem_q      <= '{default: 8'h00};
    end else begin
      cnt_q      <= cnt_d;
      op_wr_q    <= op_wr_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
      mem_q      <= mem_d;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;

`ifdef IO_TRACE_EN
  always_ff @(posedge clk_sys) begin
    if (reset_n && fire) begin
      $display("IO %s addr=%x data=%x w=%b", op_wr_q ? "wr" : "rd", addr_q,
               op_wr_q ? wdata_q : rd_val, word_q);
      if (!lo_map || (word_q && !hi_map))
        $display("IO warning: unmapped byte in access at addr=%x w=%b", addr_q, word_q);
    end
  end
`else
  // Tracing compiled out; behaviour is unchanged.
`endif

endmodule

// File: tb/tb_z86_io_sim.sv
// Bench for z86_io_sim: two instances (latency 1 and 5) checked against a byte-array reference model.
module tb_z86_io_sim;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rd_do [2];
  logic [15:0] rd_addr [2];
  logic        rd_word [2];
  logic [15:0] rd_data [2];
  logic        rd_done [2];
  logic        wr_do [2];
  logic [15:0] wr_addr [2];
  logic        wr_word [2];
  logic [15:0] wr_data [2];
  logic        wr_done [2];
  logic [15:0] rd_cnt [2];
  logic [15:0] wr_cnt [2];

  int          n_chk  = 0;
  int          n_fail = 0;
  int          lat_of [2] = '{1, 5};

  logic [7:0]  mmem [2][16];
  int          m_rd [2];
  int          m_wr [2];

  always #5 clk = ~clk;

  z86_io_sim #(.NPORTS(8), .BASE_ADDR(16'h0300), .LATENCY(1), .DEFAULT_DATA(16'hFFFF)) u0 (
    .clk_sys(clk), .reset_n(reset_n),
    .io_read_do(rd_do[0]), .io_read_address(rd_addr[0]), .io_read_word(rd_word[0]),
    .io_read_data(rd_data[0]), .io_read_done(rd_done[0]),
    .io_write_do(wr_do[0]), .io_write_address(wr_addr[0]), .io_write_word(wr_word[0]),
    .io_write_data(wr_data[0]), .io_write_done(wr_done[0]),
    .rd_count(rd_cnt[0]), .wr_count(wr_cnt[0]));

  z86_io_sim #(.NPORTS(8), .BASE_ADDR(16'h0300), .LATENCY(5), .DEFAULT_DATA(16'hFFFF)) u1 (
    .clk_sys(clk), .reset_n(reset_n),
    .io_read_do(rd_do[1]), .io_read_address(rd_addr[1]), .io_read_word(rd_word[1]),
    .io_read_data(rd_data[1]), .io_read_done(rd_done[1]),
    .io_write_do(wr_do[1]), .io_write_address(wr_addr[1]), .io_write_word(wr_word[1]),
    .io_write_data(wr_data[1]), .io_write_done(wr_done[1]),
    .rd_count(rd_cnt[1]), .wr_count(wr_cnt[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: window is 16 bytes starting at 0x0300; anything else reads as FF.
  function automatic int m_off(input logic [15:0] a);
    logic [15:0] o;
    o = a - 16'h0300;
    return int'(o);
  endfunction

  function automatic logic [15:0] m_read(input int k, input logic [15:0] a, input bit w);
    logic [15:0] a1;
    logic [7:0]  lo, hi;
    a1 = a + 16'd1;
    lo = (m_off(a) < 16) ? mmem[k][m_off(a)] : 8'hFF;
    hi = (w && m_off(a1) < 16) ? mmem[k][m_off(a1)] : 8'hFF;
    return {hi, lo};
  endfunction

  task automatic m_write(input int k, input logic [15:0] a, input bit w, input logic [15:0] d);
    logic [15:0] a1;
    a1 = a + 16'd1;
    if (m_off(a) < 16) mmem[k][m_off(a)] = d[7:0];
    if (w && m_off(a1) < 16) mmem[k][m_off(a1)] = d[15:8];
  endtask

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) mmem[k][i] = 8'h00;
      m_rd[k] = 0;
      m_wr[k] = 0;
    end
  endtask

  // One access from IDLE; returns at a negedge with the responder back in IDLE.
  task automatic access(input int k, input bit wr, input logic [15:0] a, input bit w,
                        input logic [15:0] d);
    int          n;
    bit          seen;
    logic [15:0] exp;
    exp = 16'h0;
    if (wr) begin
      wr_addr[k] = a; wr_word[k] = w; wr_data[k] = d; wr_do[k] = 1'b1;
    end else begin
      rd_addr[k] = a; rd_word[k] = w; rd_do[k] = 1'b1;
    end
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (wr ? wr_done[k] : rd_done[k]) seen = 1'b1;
    end
    chk(wr ? "wr_latency" : "rd_latency", 32'(n), 32'(lat_of[k]));
    chk("other_done_quiet", 32'(wr ? rd_done[k] : wr_done[k]), 32'd0);
    if (wr) begin
      m_write(k, a, w, d);
      if (m_wr[k] < 65535) m_wr[k]++;
    end else begin
      exp = m_read(k, a, w);
      chk("rd_data", 32'(rd_data[k]), 32'(exp));
      if (m_rd[k] < 65535) m_rd[k]++;
    end
    wr_do[k] = 1'b0;
    rd_do[k] = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", 32'(wr ? wr_done[k] : rd_done[k]), 32'd0);
    if (!wr) chk("rd_data_held", 32'(rd_data[k]), 32'(exp));
    chk("rd_count", 32'(rd_cnt[k]), 32'(m_rd[k]));
    chk("wr_count", 32'(wr_cnt[k]), 32'(m_wr[k]));
    @(negedge clk);
  endtask

  function automatic logic [15:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return 16'($urandom);
    return 16'h02FA + 16'($urandom_range(0, 28));
  endfunction

  initial begin
    int          wr_n, rd_n;
    bit          both;
    logic [15:0] obs, d4;
    reset_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rd_do[k] = 1'b0; rd_addr[k] = 16'h0; rd_word[k] = 1'b0;
      wr_do[k] = 1'b0; wr_addr[k] = 16'h0; wr_word[k] = 1'b0; wr_data[k] = 16'h0;
    end
    m_reset();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_rd_data", 32'(rd_data[k]), 32'hFFFF);
      chk("reset_rd_done", 32'(rd_done[k]), 32'd0);
      chk("reset_wr_done", 32'(wr_done[k]), 32'd0);
      chk("reset_rd_count", 32'(rd_cnt[k]), 32'd0);
      chk("reset_wr_count", 32'(wr_cnt[k]), 32'd0);
    end
    reset_n = 1'b1;
    @(negedge clk);

    // Directed: unmapped read, word write/read, straddling word, address wrap.
    access(0, 1'b0, 16'h0060, 1'b0, 16'h0);
    access(0, 1'b1, 16'h0302, 1'b1, 16'hA55A);
    access(0, 1'b0, 16'h0302, 1'b1, 16'h0);
    access(0, 1'b0, 16'h0303, 1'b0, 16'h0);
    access(0, 1'b1, 16'h030F, 1'b1, 16'h1234);
    access(0, 1'b0, 16'h030F, 1'b1, 16'h0);
    access(0, 1'b0, 16'h0310, 1'b0, 16'h0);
    access(0, 1'b1, 16'h02FF, 1'b1, 16'hBEEF);
    access(0, 1'b0, 16'h02FF, 1'b1, 16'h0);
    access(0, 1'b0, 16'hFFFF, 1'b1, 16'h0);

    // Random traffic on both instances.
    for (int i = 0; i < 60; i++)
      access(0, 1'($urandom_range(0, 1)), rand_addr(), 1'($urandom_range(0, 1)), 16'($urandom));
    for (int i = 0; i < 20; i++)
      access(1, 1'($urandom_range(0, 1)), rand_addr(), 1'($urandom_range(0, 1)), 16'($urandom));

    // Simultaneous read and write on the latency-5 instance, same address.
    d4 = 16'($urandom);
    wr_addr[1] = 16'h0304; wr_word[1] = 1'b1; wr_data[1] = d4; wr_do[1] = 1'b1;
    rd_addr[1] = 16'h0304; rd_word[1] = 1'b1; rd_do[1] = 1'b1;
    wr_n = 0; rd_n = 0; both = 1'b0; obs = 16'h0;
    for (int n = 1; n <= 40 && rd_n == 0; n++) begin
      @(negedge clk);
      if (wr_done[1] && rd_done[1]) both = 1'b1;
      if (wr_done[1]) begin
        if (wr_n == 0) wr_n = n;
        wr_do[1] = 1'b0;
      end
      if (rd_done[1]) begin
        rd_n = n;
        obs = rd_data[1];
        rd_do[1] = 1'b0;
      end
    end
    wr_do[1] = 1'b0;
    rd_do[1] = 1'b0;
    m_write(1, 16'h0304, 1'b1, d4);
    if (m_wr[1] < 65535) m_wr[1]++;
    if (m_rd[1] < 65535) m_rd[1]++;
    chk("both_wr_cycle", 32'(wr_n), 32'd5);
    chk("both_rd_cycle", 32'(rd_n), 32'd12);
    chk("both_no_overlap", 32'(both), 32'd0);
    chk("both_rd_data", 32'(obs), 32'(m_read(1, 16'h0304, 1'b1)));
    @(negedge clk);
    @(negedge clk);
    chk("both_rd_count", 32'(rd_cnt[1]), 32'(m_rd[1]));
    chk("both_wr_count", 32'(wr_cnt[1]), 32'(m_wr[1]));

    // Read counter saturation: preload near the top, then keep reading.
    force u0.rd_count_q = 16'hFFFC;
    @(negedge clk);
    release u0.rd_count_q;
    @(negedge clk);
    m_rd[0] = 16'hFFFC;
    chk("sat_preload", 32'(rd_cnt[0]), 32'hFFFC);
    for (int i = 0; i < 6; i++) access(0, 1'b0, 16'h0300 + 16'(i), 1'b0, 16'h0);

    // Reset during BUSY: access abandoned, window and counters cleared.
    rd_addr[1] = 16'h0304; rd_word[1] = 1'b1; rd_do[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst_no_done", 32'(rd_done[1]), 32'd0);
    end
    rd_do[1] = 1'b0;
    m_reset();
    reset_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_rd_count", 32'(rd_cnt[k]), 32'd0);
      chk("rst_wr_count", 32'(wr_cnt[k]), 32'd0);
    end
    access(1, 1'b0, 16'h0300, 1'b1, 16'h0);
    access(1, 1'b0, 16'h0304, 1'b1, 16'h0);
    access(0, 1'b0, 16'h0302, 1'b1, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
